// File: rtl/mc_control32.sv
// mc_control32: multi-cycle MIPS control sequencer (RST/IF/ID/EX/MEM/WB/IOW).
// Define CONTROL_IO_TIMEOUT_EN to abort I/O waits after IO_TIMEOUT cycles and flag io_err.
module mc_control32 #(
  parameter int                     ADDR_HIGH_W   = 22,
  parameter logic [ADDR_HIGH_W-1:0] IO_HIGH_VALUE = {ADDR_HIGH_W{1'b1}},
  parameter int                     MEM_LAT       = 1,
  parameter int                     IO_TIMEOUT    = 255
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [5:0]             Opcode,
  input  logic [5:0]             Function_opcode,
  input  logic [ADDR_HIGH_W-1:0] Alu_resultHigh,
  input  logic                   io_ready,
  output logic                   IRWrite,
  output logic                   PCWrite,
  output logic [1:0]             PCSrc,
  output logic                   RegWrite,
  output logic                   RegDST,
  output logic                   Jal,
  output logic                   MemorIOtoReg,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IORead,
  output logic                   IOWrite,
  output logic                   ALUSrc,
  output logic                   I_format,
  output logic                   Sftmd,
  output logic [1:0]             ALUOp,
  output logic                   illegal,
  output logic                   io_err,
  output logic [2:0]             state
);

  localparam logic [2:0] S_RST = 3'd0;
  localparam logic [2:0] S_IF  = 3'd1;
  localparam logic [2:0] S_ID  = 3'd2;
  localparam logic [2:0] S_EX  = 3'd3;
  localparam logic [2:0] S_MEM = 3'd4;
  localparam logic [2:0] S_WB  = 3'd5;
  localparam logic [2:0] S_IOW = 3'd6;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  typedef struct packed {
    logic r, lw, sw, beq, bne, j, jal, jr, ifmt, sft, ill;
  } flags_t;

  logic [2:0] state_q, state_d, done_state;
  flags_t     flags_q, flags_d, dec;
  logic       io_sel_q, io_sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;

  always_comb begin
    dec      = '0;
    dec.r    = (Opcode == 6'h00);
    dec.j    = (Opcode == 6'h02);
    dec.jal  = (Opcode == 6'h03);
    dec.beq  = (Opcode == 6'h04);
    dec.bne  = (Opcode == 6'h05);
    dec.lw   = (Opcode == 6'h23);
    dec.sw   = (Opcode == 6'h2b);
    dec.ifmt = (Opcode[5:3] == 3'b001);
    dec.jr   = dec.r && (Function_opcode == 6'h08);
    dec.sft  = dec.r && (Function_opcode inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07});
    dec.ill  = !(dec.r || dec.j || dec.jal || dec.beq || dec.bne || dec.lw || dec.sw || dec.ifmt);
  end

  assign done_state = flags_q.lw ? S_WB : S_IF;

`ifdef CONTROL_IO_TIMEOUT_EN
  localparam logic [7:0] TMO_LOAD = 8'(IO_TIMEOUT - 1);
  logic [7:0] tmo_q, tmo_d;
  logic       io_err_q, io_err_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q    <= '0;
      io_err_q <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      io_err_q <= io_err_d;
    end
  end

  assign io_err = io_err_q;
`else
  logic unused_io_timeout;
  assign unused_io_timeout = |IO_TIMEOUT;
  assign io_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    io_sel_d  = io_sel_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
`ifdef CONTROL_IO_TIMEOUT_EN
    tmo_d     = tmo_q;
    io_err_d  = io_err_q;
`endif
    case (state_q)
      S_RST: state_d = S_IF;
      S_IF:  state_d = S_ID;
      S_ID: begin
        state_d   = S_EX;
        flags_d   = dec;
        illegal_d = illegal_q | dec.ill;
      end
      S_EX: begin
        io_sel_d = (Alu_resultHigh == IO_HIGH_VALUE);
        cnt_d    = CNT_LOAD;
`ifdef CONTROL_IO_TIMEOUT_EN
        tmo_d    = TMO_LOAD;
`endif
        if (flags_q.j || flags_q.jr || flags_q.beq || flags_q.bne || flags_q.ill)
          state_d = S_IF;
        else if (flags_q.lw || flags_q.sw)
          state_d = S_MEM;
        else
          state_d = S_WB;
      end
      S_MEM: begin
        if (io_sel_q)
          state_d = io_ready ? done_state : S_IOW;
        else if (cnt_q == 4'd0)
          state_d = done_state;
        else
          cnt_d = cnt_q - 4'd1;
      end
      S_IOW: begin
        if (io_ready) state_d = done_state;
`ifdef CONTROL_IO_TIMEOUT_EN
        else if (tmo_q == 8'd0) begin
          state_d  = S_IF;
          io_err_d = 1'b1;
        end
        else tmo_d = tmo_q - 8'd1;
`endif
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      flags_q   <= '0;
      io_sel_q  <= 1'b0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      io_sel_q  <= io_sel_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Illegal opcodes retire as a NOP, so EX advances the PC itself.
  always_comb begin
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCSrc        = 2'b00;
    RegWrite     = 1'b0;
    RegDST       = 1'b0;
    Jal          = 1'b0;
    MemorIOtoReg = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IORead       = 1'b0;
    IOWrite      = 1'b0;
    ALUSrc       = 1'b0;
    I_format     = 1'b0;
    Sftmd        = 1'b0;
    ALUOp        = 2'b00;
    case (state_q)
      S_IF: IRWrite = 1'b1;
      S_EX: begin
        ALUSrc   = flags_q.ifmt | flags_q.lw | flags_q.sw;
        I_format = flags_q.ifmt;
        Sftmd    = flags_q.sft;
        if (flags_q.r || flags_q.ifmt)       ALUOp = 2'b10;
        else if (flags_q.beq || flags_q.bne) ALUOp = 2'b01;
        if (flags_q.j || flags_q.jal) begin
          PCWrite = 1'b1;
          PCSrc   = 2'b10;
        end else if (flags_q.jr) begin
          PCWrite = 1'b1;
          PCSrc   = 2'b11;
        end else if (flags_q.beq || flags_q.bne) begin
          PCWrite = 1'b1;
          PCSrc   = 2'b01;
        end else if (flags_q.ill) begin
          PCWrite = 1'b1;
        end
      end
      S_MEM, S_IOW: begin
        if (io_sel_q) begin
          IORead  = flags_q.lw;
          IOWrite = flags_q.sw;
          PCWrite = flags_q.sw & io_ready;
        end else begin
          MemRead  = flags_q.lw;
          MemWrite = flags_q.sw;
          PCWrite  = flags_q.sw & (cnt_q == 4'd0);
        end
`ifdef CONTROL_IO_TIMEOUT_EN
        if (state_q == S_IOW && !io_ready && tmo_q == 8'd0) PCWrite = 1'b1;
`endif
      end
      S_WB: begin
        RegWrite     = 1'b1;
        RegDST       = flags_q.r;
        Jal          = flags_q.jal;
        MemorIOtoReg = flags_q.lw;
        PCWrite      = !flags_q.jal;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_control32.sv
// Randomized bench for mc_control32: a per-instruction cycle trace model is compared every cycle.
// Build with CONTROL_IO_TIMEOUT_EN defined to also exercise the I/O timeout path.
module tb_mc_control32;
  localparam int              AW  = 22;
  localparam int              LAT = 3;
  localparam int              TMO = 10;
  localparam logic [AW-1:0]   IOV = {AW{1'b1}};

  typedef struct packed {
    logic [2:0] st;
    logic       irw, pcw;
    logic [1:0] pcs;
    logic       rw, rdst, jal, m2r, mr, mw, ior, iow, asrc, ifm, sft;
    logic [1:0] aop;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic ill;
    logic err;
  } step_t;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    Opcode = '0, Function_opcode = '0;
  logic [AW-1:0] Alu_resultHigh = '0;
  logic          io_ready = 1'b0;
  logic          IRWrite, PCWrite, RegWrite, RegDST, Jal, MemorIOtoReg;
  logic          MemRead, MemWrite, IORead, IOWrite, ALUSrc, I_format, Sftmd;
  logic          illegal, io_err;
  logic [1:0]    PCSrc, ALUOp;
  logic [2:0]    state;
  obs_t          obs;

  int   n_chk = 0, n_err = 0;
  bit   m_ill = 1'b0, m_err = 1'b0;
  step_t exp_q[$];

  mc_control32 #(.ADDR_HIGH_W(AW), .IO_HIGH_VALUE(IOV), .MEM_LAT(LAT), .IO_TIMEOUT(TMO)) dut (
    .clock(clock), .rst_n(rst_n), .Opcode(Opcode), .Function_opcode(Function_opcode),
    .Alu_resultHigh(Alu_resultHigh), .io_ready(io_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .RegDST(RegDST), .Jal(Jal), .MemorIOtoReg(MemorIOtoReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .IORead(IORead), .IOWrite(IOWrite), .ALUSrc(ALUSrc),
    .I_format(I_format), .Sftmd(Sftmd), .ALUOp(ALUOp), .illegal(illegal), .io_err(io_err),
    .state(state)
  );

  assign obs = {state, IRWrite, PCWrite, PCSrc, RegWrite, RegDST, Jal, MemorIOtoReg,
                MemRead, MemWrite, IORead, IOWrite, ALUSrc, I_format, Sftmd, ALUOp};

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input obs_t o);
    step_t s;
    s.o   = o;
    s.ill = m_ill;
    s.err = m_err;
    exp_q.push_back(s);
  endtask

  // Expected cycle trace of one instruction, derived from the instruction class.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit io,
                       input int wn, input bit abort);
    bit r, j, jal, jr, beq, bne, lw, sw, ifm, sft, ill;
    int n;
    obs_t o;
    r   = (op == 6'h00); j = (op == 6'h02); jal = (op == 6'h03);
    beq = (op == 6'h04); bne = (op == 6'h05);
    lw  = (op == 6'h23); sw = (op == 6'h2b); ifm = (op[5:3] == 3'b001);
    jr  = r && (fn == 6'h08);
    sft = r && (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07});
    ill = !(r || j || jal || beq || bne || lw || sw || ifm);

    o = '0; o.st = 3'd1; o.irw = 1'b1; put(o);
    o = '0; o.st = 3'd2; put(o);
    o = '0; o.st = 3'd3;
    o.aop  = (r || ifm) ? 2'b10 : ((beq || bne) ? 2'b01 : 2'b00);
    o.asrc = ifm || lw || sw; o.ifm = ifm; o.sft = sft;
    if (j || jal)        begin o.pcw = 1'b1; o.pcs = 2'b10; end
    else if (jr)         begin o.pcw = 1'b1; o.pcs = 2'b11; end
    else if (beq || bne) begin o.pcw = 1'b1; o.pcs = 2'b01; end
    else if (ill)        begin o.pcw = 1'b1; o.pcs = 2'b00; end
    if (ill) m_ill = 1'b1;
    put(o);

    if (lw || sw) begin
      if (io) begin
        n = abort ? TMO + 1 : wn + 1;
        for (int k = 0; k < n; k++) begin
          o = '0; o.st = (k == 0) ? 3'd4 : 3'd6;
          o.ior = lw; o.iow = sw;
          o.pcw = (k == n - 1) && (sw || abort);
          put(o);
        end
        if (abort) begin
          m_err = 1'b1;
          return;
        end
      end else begin
        for (int k = 0; k < LAT; k++) begin
          o = '0; o.st = 3'd4; o.mr = lw; o.mw = sw;
          o.pcw = sw && (k == LAT - 1);
          put(o);
        end
      end
      if (!lw) return;
    end else if (j || jr || beq || bne || ill) begin
      return;
    end
    o = '0; o.st = 3'd5; o.rw = 1'b1; o.rdst = r; o.jal = jal; o.m2r = lw; o.pcw = !jal;
    put(o);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [AW-1:0] ah, input int wn, input bit abort);
    int    idx;
    bit    io, acc;
    step_t s;
    io  = (ah == IOV);
    acc = (op == 6'h23) || (op == 6'h2b);
    build(op, fn, io, wn, abort);
    Opcode = op; Function_opcode = fn; Alu_resultHigh = ah;
    idx = 0;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      @(negedge clock);
      if (acc && io && idx >= 3) io_ready = !abort && (idx - 3 >= wn);
      else                       io_ready = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("op%h step%0d outputs", op, idx), {12'b0, obs}, {12'b0, s.o});
      chk($sformatf("op%h step%0d illegal", op, idx), {31'b0, illegal}, {31'b0, s.ill});
      chk($sformatf("op%h step%0d io_err", op, idx), {31'b0, io_err}, {31'b0, s.err});
      idx++;
    end
  endtask

  task automatic random_instr();
    logic [5:0]    op, fn;
    logic [AW-1:0] ah;
    int            cls;
    cls = $urandom_range(0, 9);
    fn  = 6'($urandom);
    ah  = AW'($urandom);
    if (ah == IOV) ah = '0;
    case (cls)
      0: begin op = 6'h00; if (fn == 6'h08) fn = 6'h20; end
      1: begin op = 6'h00; fn = 6'h08; end
      2: op = 6'h02;
      3: op = 6'h03;
      4: op = 6'h04;
      5: op = 6'h05;
      6: op = 6'h23;
      7: op = 6'h2b;
      8: op = {3'b001, 3'($urandom)};
      default: begin
        do op = 6'($urandom);
        while (op == 6'h00 || op == 6'h02 || op == 6'h03 || op == 6'h04 || op == 6'h05 ||
               op == 6'h23 || op == 6'h2b || op[5:3] == 3'b001);
      end
    endcase
    if ((cls == 6 || cls == 7) && $urandom_range(0, 1) == 1) ah = IOV;
    run_instr(op, fn, ah, $urandom_range(0, 6), 1'b0);
  endtask

  // Reset pulse while the DUT is mid-instruction; strobes and flags must clear at once.
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, " async outputs"}, {12'b0, obs}, 32'd0);
    chk({tag, " async illegal"}, {31'b0, illegal}, 32'd0);
    chk({tag, " async io_err"}, {31'b0, io_err}, 32'd0);
    m_ill = 1'b0;
    m_err = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    chk({tag, " rst state"}, {12'b0, obs}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1;
    chk("reset outputs", {12'b0, obs}, 32'd0);
    chk("reset illegal", {31'b0, illegal}, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    chk("first cycle after reset", {12'b0, obs}, 32'd0);

    run_instr(6'h00, 6'h20, '0, 0, 1'b0);
    run_instr(6'h23, 6'h00, '0, 0, 1'b0);
    run_instr(6'h2b, 6'h00, IOV, 5, 1'b0);
    run_instr(6'h3f, 6'h00, '0, 0, 1'b0);
    run_instr(6'h23, 6'h00, IOV, 0, 1'b0);
    for (int i = 0; i < 60; i++) random_instr();

    Opcode = 6'h23; Function_opcode = '0; Alu_resultHigh = '0; io_ready = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    chk("mid-lw state before reset", {29'b0, state}, 32'd4);
    reset_pulse("mem reset");

`ifdef CONTROL_IO_TIMEOUT_EN
    run_instr(6'h23, 6'h00, IOV, 0, 1'b1);
    run_instr(6'h00, 6'h25, '0, 0, 1'b0);
    Opcode = 6'h23; Function_opcode = '0; Alu_resultHigh = IOV; io_ready = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    chk("iow state before reset", {29'b0, state}, 32'd6);
    chk("io_err before reset", {31'b0, io_err}, 32'd1);
    reset_pulse("iow reset");
`endif

    for (int i = 0; i < 15; i++) random_instr();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
